// File: rtl/br_lite_ni_pkg.sv
// Shared BrLite types: flit layout, service codes, router port names and the
// local network-interface FSM state types.
package br_lite_ni_pkg;

  localparam int unsigned BR_ADDR_W    = 16;
  localparam int unsigned BR_ID_W      = 8;
  localparam int unsigned BR_SVC_W     = 2;
  localparam int unsigned BR_PAYLOAD_W = 32;

  localparam logic [BR_SVC_W-1:0] BR_SVC_ALL   = 2'd0;
  localparam logic [BR_SVC_W-1:0] BR_SVC_TGT   = 2'd1;
  localparam logic [BR_SVC_W-1:0] BR_SVC_CLEAR = 2'd2;

  typedef struct packed {
    logic [BR_ADDR_W-1:0]    source;
    logic [BR_ADDR_W-1:0]    target;
    logic [BR_ID_W-1:0]      id;
    logic [BR_SVC_W-1:0]     service;
    logic [BR_PAYLOAD_W-1:0] payload;
  } br_data_t;

  typedef enum logic [2:0] {
    BR_EAST,
    BR_WEST,
    BR_NORTH,
    BR_SOUTH,
    BR_LOCAL
  } br_port_t;

  typedef enum logic [2:0] {
    TxIdle,
    TxCheck,
    TxWaitBusy,
    TxReq,
    TxWaitAckLow
  } br_ni_tx_state_t;

  typedef enum logic [0:0] {
    RxIdle,
    RxAck
  } br_ni_rx_state_t;

endpackage

// File: rtl/br_lite_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty come from registered
// pointers, so a push into a full FIFO is refused even when a pop happens.
module br_lite_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        push_en, pop_en;
  T            mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/br_lite_ni.sv
// Local network interface between a PE and the BrLite router LOCAL port:
// TX builds and sends flits via 4-phase req/ack, RX buffers delivered flits.
module br_lite_ni
  import br_lite_ni_pkg::*;
#(
  parameter logic [BR_ADDR_W-1:0] ADDRESS  = 16'h0000,
  parameter int unsigned          RX_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [BR_SVC_W-1:0]     tx_service_i,
  input  logic [BR_ADDR_W-1:0]    tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
  output logic                    tx_drop_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output br_data_t                rx_data_o,
  output br_data_t                br_flit_o,
  output logic                    br_req_o,
  input  logic                    br_ack_i,
  input  br_data_t                br_flit_i,
  input  logic                    br_req_i,
  output logic                    br_ack_o,
  input  logic                    br_busy_i
);

  localparam logic [BR_ID_W-1:0] ID_ONE = 1;

  br_ni_tx_state_t tx_state_q, tx_state_d;
  br_ni_rx_state_t rx_state_q, rx_state_d;
  br_data_t        flit_q;
  logic [BR_ID_W-1:0] id_q;
  logic            svc_legal;
  logic            fifo_full, fifo_empty, fifo_push;

  assign svc_legal = (tx_service_i == BR_SVC_ALL) || (tx_service_i == BR_SVC_TGT);

  // ---------------- TX path ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tx_state_q <= TxIdle;
    else         tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TxIdle:       if (tx_valid_i) tx_state_d = TxCheck;
      TxCheck:      tx_state_d = svc_legal ? TxWaitBusy : TxIdle;
      TxWaitBusy:   if (!br_busy_i) tx_state_d = TxReq;
      TxReq:        if (br_ack_i) tx_state_d = TxWaitAckLow;
      TxWaitAckLow: if (!br_ack_i) tx_state_d = TxIdle;
      default:      tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_ready_o = (tx_state_q == TxCheck);
    tx_drop_o  = (tx_state_q == TxCheck) && !svc_legal;
    br_req_o   = (tx_state_q == TxReq);
  end

  // The flit register only changes on acceptance, so br_flit_o is stable during req.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flit_q <= '0;
      id_q   <= '0;
    end else begin
      if (tx_state_q == TxCheck && svc_legal) begin
        flit_q.source  <= ADDRESS;
        flit_q.target  <= (tx_service_i == BR_SVC_ALL) ? '0 : tx_target_i;
        flit_q.id      <= id_q;
        flit_q.service <= tx_service_i;
        flit_q.payload <= tx_payload_i;
      end
      if (tx_state_q == TxReq && br_ack_i) id_q <= id_q + ID_ONE;
    end
  end

  assign br_flit_o = flit_q;

  // ---------------- RX path ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_state_q <= RxIdle;
    else         rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxIdle:  if (br_req_i && !fifo_full) rx_state_d = RxAck;
      RxAck:   if (!br_req_i) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  // CLEAR flits complete the handshake but never reach the PE.
  always_comb begin
    br_ack_o  = (rx_state_q == RxAck);
    fifo_push = (rx_state_q == RxIdle) && br_req_i && !fifo_full &&
                (br_flit_i.service != BR_SVC_CLEAR);
  end

  br_lite_fifo #(
    .DEPTH (RX_DEPTH),
    .T     (br_data_t)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (br_flit_i),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid_o = !fifo_empty;

endmodule

// File: tb/tb_br_lite_ni.sv
// Randomized self-checking bench for br_lite_ni against a transaction-level
// model (expected id counter, expected flit, RX queue).
module tb_br_lite_ni;
  import br_lite_ni_pkg::*;

  localparam logic [15:0] ADDR  = 16'h0102;
  localparam int unsigned DEPTH = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    tx_valid_i = 1'b0;
  logic                    tx_ready_o;
  logic [BR_SVC_W-1:0]     tx_service_i = '0;
  logic [15:0]             tx_target_i = '0;
  logic [BR_PAYLOAD_W-1:0] tx_payload_i = '0;
  logic                    tx_drop_o;
  logic                    rx_valid_o;
  logic                    rx_ready_i = 1'b0;
  br_data_t                rx_data_o;
  br_data_t                br_flit_o;
  logic                    br_req_o;
  logic                    br_ack_i = 1'b0;
  br_data_t                br_flit_i = '0;
  logic                    br_req_i = 1'b0;
  logic                    br_ack_o;
  logic                    br_busy_i = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  logic [BR_ID_W-1:0] exp_id = '0;
  br_data_t exp_flit = '0;
  br_data_t rx_q[$];

  br_lite_ni #(
    .ADDRESS  (ADDR),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_service_i (tx_service_i),
    .tx_target_i  (tx_target_i),
    .tx_payload_i (tx_payload_i),
    .tx_drop_o    (tx_drop_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o),
    .br_flit_o    (br_flit_o),
    .br_req_o     (br_req_o),
    .br_ack_i     (br_ack_i),
    .br_flit_i    (br_flit_i),
    .br_req_i     (br_req_i),
    .br_ack_o     (br_ack_o),
    .br_busy_i    (br_busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic br_data_t make_flit(input logic [1:0] svc, input logic [15:0] tgt,
                                         input logic [31:0] pl, input logic [7:0] id);
    br_data_t f;
    f.source  = ADDR;
    f.id      = id;
    f.service = svc;
    f.target  = (svc == BR_SVC_ALL) ? 16'h0 : tgt;
    f.payload = pl;
    return f;
  endfunction

  function automatic br_data_t rand_flit(input logic [1:0] svc);
    br_data_t f;
    f.source  = 16'($urandom);
    f.target  = 16'($urandom);
    f.id      = 8'($urandom);
    f.service = svc;
    f.payload = 32'($urandom);
    return f;
  endfunction

  // PE side: present a request, lat = cycles from valid shown to ready seen (inclusive).
  task automatic pe_request(input logic [1:0] svc, input logic [15:0] tgt,
                            input logic [31:0] pl, output int lat, output logic drop,
                            output logic ready_again);
    tx_service_i = svc;
    tx_target_i  = tgt;
    tx_payload_i = pl;
    tx_valid_i   = 1'b1;
    lat  = 1;
    drop = 1'b0;
    while (lat < 6) begin
      step();
      lat++;
      if (tx_ready_o) break;
    end
    if (tx_ready_o) drop = tx_drop_o;
    else lat = 99;
    tx_valid_i = 1'b0;
    step();
    ready_again = tx_ready_o;
  endtask

  // Router side of the TX handshake: wait for req, ack after ack_delay further cycles.
  task automatic router_accept(input int ack_delay, output int wait_n, output int hi_n,
                               output br_data_t flit, output logic fell);
    wait_n = 0;
    while (!br_req_o && wait_n < 200) begin
      step();
      wait_n++;
    end
    hi_n = 0;
    for (int i = 0; i < ack_delay; i++) begin
      if (br_req_o) hi_n++;
      step();
    end
    if (br_req_o) hi_n++;
    flit = br_flit_o;
    br_ack_i = 1'b1;
    step();
    fell = !br_req_o;
    br_ack_i = 1'b0;
    step();
  endtask

  // Router side of the RX handshake: raise req, wait up to max_wait cycles for ack.
  task automatic router_send(input br_data_t f, input int max_wait, output logic acked,
                             output int waited);
    br_flit_i = f;
    br_req_i  = 1'b1;
    waited    = 0;
    while (!br_ack_o && waited < max_wait) begin
      step();
      waited++;
    end
    acked = br_ack_o;
    if (acked) begin
      br_req_i  = 1'b0;
      br_flit_i = rand_flit(2'($urandom));
      step();
    end
  endtask

  task automatic pe_pop(output logic v, output br_data_t d);
    v = rx_valid_o;
    d = rx_data_o;
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    n_vec++;
    if ({tx_ready_o, tx_drop_o, br_req_o, br_ack_o, rx_valid_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset outputs: got %b want 00000",
               {tx_ready_o, tx_drop_o, br_req_o, br_ack_o, rx_valid_o});
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_tx_basic();
    int lat, w, hi;
    logic drop, again, fell;
    br_data_t f;
    pe_request(BR_SVC_ALL, 16'($urandom), 32'hA5, lat, drop, again);
    n_vec++;
    if (lat !== 2 || drop !== 1'b0 || again !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_basic accept: lat=%0d drop=%b again=%b want 2 0 0", lat, drop, again);
    end
    exp_flit = make_flit(BR_SVC_ALL, 16'h0, 32'hA5, exp_id);
    n_vec++;
    if (br_flit_o !== exp_flit || exp_flit.id !== 8'd0) begin
      n_bad++;
      $display("FAIL tx_basic flit: got %h want %h", br_flit_o, exp_flit);
    end
    router_accept(3, w, hi, f, fell);
    n_vec++;
    if (w !== 1 || hi !== 4 || fell !== 1'b1 || f !== exp_flit) begin
      n_bad++;
      $display("FAIL tx_basic handshake: wait=%0d hi=%0d fell=%b flit=%h want 1 4 1 %h",
               w, hi, fell, f, exp_flit);
    end
    exp_id++;
    tx_target_i = 16'($urandom);
    pe_request(BR_SVC_TGT, 16'h0BEE, 32'h1234_5678, lat, drop, again);
    exp_flit = make_flit(BR_SVC_TGT, 16'h0BEE, 32'h1234_5678, exp_id);
    router_accept(0, w, hi, f, fell);
    n_vec++;
    if (f !== exp_flit || f.id !== 8'd1 || fell !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_second id: got %h want %h", f, exp_flit);
    end
    exp_id++;
  endtask

  task automatic test_tx_busy();
    int lat, w, hi, early;
    logic drop, again, fell;
    br_data_t f;
    logic [31:0] pl;
    pl = 32'($urandom);
    br_busy_i = 1'b1;
    pe_request(BR_SVC_ALL, 16'h0, pl, lat, drop, again);
    n_vec++;
    if (lat !== 2 || drop !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_busy ready: lat=%0d drop=%b want 2 0", lat, drop);
    end
    early = 0;
    for (int i = 0; i < 18; i++) begin
      if (br_req_o) early++;
      step();
    end
    n_vec++;
    if (early !== 0) begin
      n_bad++;
      $display("FAIL tx_busy req_while_busy: got %0d cycles want 0", early);
    end
    br_busy_i = 1'b0;
    router_accept(2, w, hi, f, fell);
    exp_flit = make_flit(BR_SVC_ALL, 16'h0, pl, exp_id);
    n_vec++;
    if (w !== 1 || f !== exp_flit || fell !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_busy release: wait=%0d flit=%h want 1 %h", w, f, exp_flit);
    end
    exp_id++;
  endtask

  task automatic test_tx_drop();
    int lat, w, hi, rose;
    logic drop, again, fell;
    br_data_t f;
    pe_request(BR_SVC_CLEAR, 16'($urandom), 32'($urandom), lat, drop, again);
    n_vec++;
    if (lat !== 2 || drop !== 1'b1 || again !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_drop pulse: lat=%0d drop=%b again=%b want 2 1 0", lat, drop, again);
    end
    rose = 0;
    for (int i = 0; i < 6; i++) begin
      if (br_req_o) rose++;
      step();
    end
    n_vec++;
    if (rose !== 0 || br_flit_o !== exp_flit) begin
      n_bad++;
      $display("FAIL tx_drop no_send: req_cycles=%0d flit=%h want 0 %h", rose, br_flit_o, exp_flit);
    end
    pe_request(BR_SVC_TGT, 16'h0042, 32'hCAFE, lat, drop, again);
    exp_flit = make_flit(BR_SVC_TGT, 16'h0042, 32'hCAFE, exp_id);
    router_accept(1, w, hi, f, fell);
    n_vec++;
    if (f !== exp_flit) begin
      n_bad++;
      $display("FAIL tx_drop id_unchanged: got %h want %h", f, exp_flit);
    end
    exp_id++;
  endtask

  task automatic test_tx_random();
    int lat, w, hi, busy_n, dly, early;
    logic drop, again, fell, legal;
    logic [1:0] svc;
    logic [15:0] tgt;
    logic [31:0] pl;
    br_data_t f;
    for (int n = 0; n < 24; n++) begin
      svc    = 2'($urandom_range(0, 3));
      tgt    = 16'($urandom);
      pl     = 32'($urandom);
      busy_n = $urandom_range(0, 3);
      dly    = $urandom_range(0, 4);
      legal  = (svc == BR_SVC_ALL) || (svc == BR_SVC_TGT);
      br_busy_i = (busy_n != 0);
      pe_request(svc, tgt, pl, lat, drop, again);
      n_vec++;
      if (lat !== 2 || drop !== !legal || again !== 1'b0) begin
        n_bad++;
        $display("FAIL tx_random accept[%0d]: lat=%0d drop=%b again=%b want 2 %b 0",
                 n, lat, drop, again, !legal);
      end
      if (legal) begin
        exp_flit = make_flit(svc, tgt, pl, exp_id);
        early = 0;
        for (int i = 0; i < busy_n; i++) begin
          if (br_req_o) early++;
          step();
        end
        br_busy_i = 1'b0;
        router_accept(dly, w, hi, f, fell);
        n_vec++;
        if (early !== 0 || w !== 1 || hi !== dly + 1 || fell !== 1'b1 || f !== exp_flit) begin
          n_bad++;
          $display("FAIL tx_random send[%0d]: early=%0d wait=%0d hi=%0d fell=%b flit=%h want %h",
                   n, early, w, hi, fell, f, exp_flit);
        end
        exp_id++;
      end else begin
        br_busy_i = 1'b0;
        step();
        n_vec++;
        if (br_req_o !== 1'b0 || br_flit_o !== exp_flit) begin
          n_bad++;
          $display("FAIL tx_random drop[%0d]: req=%b flit=%h want 0 %h",
                   n, br_req_o, br_flit_o, exp_flit);
        end
      end
    end
  endtask

  task automatic test_rx_fill();
    logic acked, v;
    int waited, bad;
    br_data_t f, d;
    br_data_t f5;
    rx_ready_i = 1'b0;
    bad = 0;
    for (int k = 1; k <= 4; k++) begin
      f = rand_flit(BR_SVC_ALL);
      f.payload = 32'(k);
      router_send(f, 4, acked, waited);
      if (!acked || waited != 1) bad++;
      rx_q.push_back(f);
    end
    n_vec++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL rx_fill first_four: %0d handshakes late or missing, want 0", bad);
    end
    f5 = rand_flit(BR_SVC_TGT);
    f5.payload = 32'd5;
    router_send(f5, 4, acked, waited);
    n_vec++;
    if (acked !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_fill fifth_stalled: ack=%b want 0", acked);
    end
    pe_pop(v, d);
    n_vec++;
    if (v !== 1'b1 || d !== rx_q[0] || d.payload !== 32'd1) begin
      n_bad++;
      $display("FAIL rx_fill pop_head: valid=%b data=%h want 1 %h", v, d, rx_q[0]);
    end
    void'(rx_q.pop_front());
    n_vec++;
    if (br_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_fill push_deferred: ack=%b want 0", br_ack_o);
    end
    step();
    n_vec++;
    if (br_ack_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_fill fifth_acked: ack=%b want 1", br_ack_o);
    end
    rx_q.push_back(f5);
    br_req_i = 1'b0;
    step();
    bad = 0;
    while (rx_q.size() > 0) begin
      f = rx_q.pop_front();
      pe_pop(v, d);
      if (v !== 1'b1 || d !== f) bad++;
    end
    n_vec++;
    if (bad !== 0 || rx_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_fill order: %0d wrong entries, valid=%b, want 0 0", bad, rx_valid_o);
    end
  endtask

  task automatic test_rx_long_req();
    int hi;
    logic v;
    br_data_t f, d;
    f = rand_flit(BR_SVC_ALL);
    br_flit_i = f;
    br_req_i  = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (br_ack_o) hi++;
    end
    br_req_i = 1'b0;
    n_vec++;
    if (hi !== 10) begin
      n_bad++;
      $display("FAIL rx_long ack_held: got %0d cycles want 10", hi);
    end
    step();
    n_vec++;
    if (br_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_long ack_fall: ack=%b want 0", br_ack_o);
    end
    pe_pop(v, d);
    n_vec++;
    if (v !== 1'b1 || d !== f || rx_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_long one_entry: valid=%b data=%h after=%b want 1 %h 0",
               v, d, rx_valid_o, f);
    end
  endtask

  task automatic test_rx_random();
    logic acked, v;
    int waited;
    br_data_t f, d, e;
    for (int n = 0; n < 30; n++) begin
      f = rand_flit(2'($urandom_range(0, 3)));
      if (rx_q.size() > 0 && (rx_q.size() == DEPTH || $urandom_range(0, 1) == 1)) begin
        e = rx_q.pop_front();
        pe_pop(v, d);
        n_vec++;
        if (v !== 1'b1 || d !== e) begin
          n_bad++;
          $display("FAIL rx_random pop[%0d]: valid=%b data=%h want 1 %h", n, v, d, e);
        end
      end
      router_send(f, 3, acked, waited);
      n_vec++;
      if (acked !== 1'b1 || waited !== 1) begin
        n_bad++;
        $display("FAIL rx_random send[%0d]: acked=%b waited=%0d want 1 1", n, acked, waited);
      end
      if (f.service != BR_SVC_CLEAR) rx_q.push_back(f);
    end
    while (rx_q.size() > 0) begin
      e = rx_q.pop_front();
      pe_pop(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== e) begin
        n_bad++;
        $display("FAIL rx_random drain: valid=%b data=%h want 1 %h", v, d, e);
      end
    end
    n_vec++;
    if (rx_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_random empty: valid=%b want 0", rx_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic acked, drop, again, fell;
    int waited, lat, w, hi, n;
    br_data_t f;
    router_send(rand_flit(BR_SVC_ALL), 3, acked, waited);
    pe_request(BR_SVC_ALL, 16'h0, 32'h0BAD, lat, drop, again);
    n = 0;
    while (!br_req_o && n < 5) begin
      step();
      n++;
    end
    n_vec++;
    if (br_req_o !== 1'b1 || rx_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid setup: req=%b rx_valid=%b want 1 1", br_req_o, rx_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (br_req_o !== 1'b0 || rx_valid_o !== 1'b0 || tx_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid async: req=%b rx_valid=%b ready=%b want 0 0 0",
               br_req_o, rx_valid_o, tx_ready_o);
    end
    step();
    step();
    rst_ni = 1'b1;
    exp_id = '0;
    rx_q.delete();
    step();
    n_vec++;
    if (br_req_o !== 1'b0 || rx_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid no_replay: req=%b rx_valid=%b want 0 0", br_req_o, rx_valid_o);
    end
    pe_request(BR_SVC_ALL, 16'h0, 32'h600D, lat, drop, again);
    exp_flit = make_flit(BR_SVC_ALL, 16'h0, 32'h600D, exp_id);
    router_accept(1, w, hi, f, fell);
    n_vec++;
    if (f !== exp_flit || f.id !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid id_restart: got %h want %h", f, exp_flit);
    end
    exp_id++;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_busy();
    test_tx_drop();
    test_tx_random();
    test_rx_fill();
    test_rx_long_req();
    test_rx_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
